// File: rtl/unidade_controle_rodadas.sv
// Round sequencer for the memory game: drives the E/L counters and play register.
// Optional per-play timeout is compiled in with `define TIMEOUT_EN.
module unidade_controle_rodadas #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int TW             = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimE,
  input  logic       fimL,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic       pronto,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIO_RODADA  = 4'h2,
    ESPERA_JOGADA  = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_ACERTO     = 4'h8,
    FIM_ERRO       = 4'h9,
    FIM_TIMEOUT    = 4'hA
  } state_t;

  state_t state_q, state_d;
  logic   timer_expired;

  // Reject parameter sets where the timer could not reach its terminal count.
  if (TIMEOUT_CYCLES < 2 || (64'd1 << TW) < 64'(TIMEOUT_CYCLES)) begin : g_param_check
    $error("unidade_controle_rodadas: TW too small for TIMEOUT_CYCLES, or TIMEOUT_CYCLES < 2");
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= INICIAL;
    else       state_q <= state_d;
  end

`ifdef TIMEOUT_EN
  logic [TW-1:0] timer_q, timer_d;

  // The timer only runs while staying in espera_jogada, so every entry starts a full window.
  always_comb begin
    timer_d = '0;
    if (state_q == ESPERA_JOGADA && state_d == ESPERA_JOGADA)
      timer_d = timer_q + TW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end

  assign timer_expired = (timer_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timer_expired = 1'b0;
`endif

  always_comb begin
    state_d   = INICIAL;
    zeraE     = 1'b0;
    contaE    = 1'b0;
    zeraL     = 1'b0;
    contaL    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    pronto    = 1'b0;
    db_estado = 4'hF;

    case (state_q)
      INICIAL: begin
        state_d   = iniciar ? PREPARACAO : INICIAL;
        zeraE     = 1'b1;
        zeraL     = 1'b1;
        zeraR     = 1'b1;
        db_estado = 4'h0;
      end
      PREPARACAO: begin
        state_d   = INICIO_RODADA;
        zeraE     = 1'b1;
        zeraL     = 1'b1;
        zeraR     = 1'b1;
        db_estado = 4'h1;
      end
      INICIO_RODADA: begin
        state_d   = ESPERA_JOGADA;
        zeraE     = 1'b1;
        db_estado = 4'h2;
      end
      ESPERA_JOGADA: begin
        if (jogada)             state_d = REGISTRA;
        else if (timer_expired) state_d = FIM_TIMEOUT;
        else                    state_d = ESPERA_JOGADA;
        db_estado = 4'h3;
      end
      REGISTRA: begin
        state_d   = COMPARACAO;
        registraR = 1'b1;
        db_estado = 4'h4;
      end
      COMPARACAO: begin
        if (!igual)             state_d = FIM_ERRO;
        else if (fimE && fimL)  state_d = FIM_ACERTO;
        else if (fimE)          state_d = PROXIMA_RODADA;
        else                    state_d = PROXIMA_JOGADA;
        db_estado = 4'h5;
      end
      PROXIMA_JOGADA: begin
        state_d   = ESPERA_JOGADA;
        contaE    = 1'b1;
        db_estado = 4'h6;
      end
      PROXIMA_RODADA: begin
        state_d   = INICIO_RODADA;
        contaL    = 1'b1;
        db_estado = 4'h7;
      end
      FIM_ACERTO: begin
        state_d   = iniciar ? PREPARACAO : FIM_ACERTO;
        acertou   = 1'b1;
        pronto    = 1'b1;
        db_estado = 4'h8;
      end
      FIM_ERRO: begin
        state_d   = iniciar ? PREPARACAO : FIM_ERRO;
        errou     = 1'b1;
        pronto    = 1'b1;
        db_estado = 4'h9;
      end
`ifdef TIMEOUT_EN
      FIM_TIMEOUT: begin
        state_d   = iniciar ? PREPARACAO : FIM_TIMEOUT;
        timeout   = 1'b1;
        pronto    = 1'b1;
        db_estado = 4'hA;
      end
`endif
      default: begin
        // Unreachable codes fall back to the idle state.
        state_d = INICIAL;
      end
    endcase
  end

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Bench for unidade_controle_rodadas: behavioural datapath plus game-level outcome model.
// Covers both builds; timeout checks only when TIMEOUT_EN is defined.
module tb_unidade_controle_rodadas;

  localparam int TO    = 10;
  localparam int TWB   = 4;
  localparam int DEPTH = 4;
`ifdef TIMEOUT_EN
  localparam int RST_WAIT = 5;
`else
  localparam int RST_WAIT = 100;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       jogada = 1'b0;
  logic       igual, fimE, fimL;
  logic       zeraE, contaE, zeraL, contaL, zeraR, registraR;
  logic       acertou, errou, timeout, pronto;
  logic [3:0] db_estado;

  unidade_controle_rodadas #(.TIMEOUT_CYCLES(TO), .TW(TWB)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .igual(igual), .fimE(fimE), .fimL(fimL),
    .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
    .zeraR(zeraR), .registraR(registraR), .acertou(acertou), .errou(errou),
    .timeout(timeout), .pronto(pronto), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Behavioural datapath: address E, limit L, play register R, stored sequence.
  logic [1:0] e_q = '0, l_q = '0;
  logic [3:0] r_q = '0;
  logic [3:0] play_val = '0;
  logic [3:0] mem [DEPTH];

  always @(posedge clock) begin
    if (zeraE) e_q <= '0; else if (contaE) e_q <= e_q + 2'd1;
    if (zeraL) l_q <= '0; else if (contaL) l_q <= l_q + 2'd1;
    if (zeraR) r_q <= '0; else if (registraR) r_q <= play_val;
  end

  assign igual = (r_q == mem[e_q]);
  assign fimE  = (e_q == l_q);
  assign fimL  = (l_q == 2'(DEPTH - 1));

  int n_conta_e = 0;
  int n_conta_l = 0;
  always @(negedge clock) begin
    if (contaE) n_conta_e <= n_conta_e + 1;
    if (contaL) n_conta_l <= n_conta_l + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_state(input logic [3:0] code, input int lim, input string tag);
    int i;
    i = 0;
    while (db_estado !== code && i < lim) begin
      @(negedge clock);
      i++;
    end
    check(tag, 32'(db_estado), 32'(code));
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Plays one game; er < 0 means every play is right, else play ep of round er is wrong.
  task automatic play_game(input int er, input int ep);
    int  ce0, cl0, exp_e, exp_l;
    bit  done, wrong;
    for (int i = 0; i < DEPTH; i++) mem[i] = 4'($urandom);
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    check("start_prep", 32'(db_estado), 32'h1);
    check("start_zeraL", 32'(zeraL), 32'h1);
    ce0 = n_conta_e;
    cl0 = n_conta_l;
    done = 1'b0;
    for (int r = 0; r < DEPTH && !done; r++) begin
      for (int p = 0; p <= r && !done; p++) begin
        wait_state(4'h3, 20, "wait_play");
        repeat ($urandom_range(0, 5)) @(negedge clock);
        wrong    = (r == er) && (p == ep);
        play_val = wrong ? (mem[p] ^ 4'h1) : mem[p];
        jogada   = 1'b1;
        @(negedge clock);
        jogada = 1'b0;
        check("lat_registraR", 32'(registraR), 32'h1);
        if (wrong) done = 1'b1;
      end
    end
    if (er < 0) begin
      exp_e = DEPTH * (DEPTH - 1) / 2;
      exp_l = DEPTH - 1;
      wait_state(4'h8, 20, "win_state");
      check("win_acertou", 32'(acertou), 32'h1);
    end else begin
      exp_e = er * (er - 1) / 2 + ep;
      exp_l = er;
      wait_state(4'h9, 20, "err_state");
      check("err_errou", 32'(errou), 32'h1);
    end
    check("end_pronto", 32'(pronto), 32'h1);
    check("count_contaE", 32'(n_conta_e - ce0), 32'(exp_e));
    check("count_contaL", 32'(n_conta_l - cl0), 32'(exp_l));
    $display("game er=%0d ep=%0d state=%0h contaE=%0d contaL=%0d", er, ep, db_estado,
             n_conta_e - ce0, n_conta_l - cl0);
  endtask

  initial begin
    int stuck;
    int n;
    repeat (2) @(negedge clock);
    check("rst_estado", 32'(db_estado), 32'h0);
    check("rst_zeras", {29'd0, zeraE, zeraL, zeraR}, 32'h7);
    check("rst_others", {24'd0, contaE, contaL, registraR, acertou, errou, timeout, pronto, 1'b0}, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    play_game(-1, 0);
    play_game(2, 1);
    for (int g = 0; g < 8; g++) begin
      int er, ep;
      if ($urandom_range(0, 2) == 0) begin
        er = -1;
        ep = 0;
      end else begin
        er = int'($urandom_range(0, DEPTH - 1));
        ep = int'($urandom_range(0, er));
      end
      play_game(er, ep);
    end

    // Asynchronous reset while waiting for a play.
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    wait_state(4'h3, 10, "rst_mid_wait");
    repeat (RST_WAIT) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("rst_async_estado", 32'(db_estado), 32'h0);
    check("rst_async_zeras", {29'd0, zeraE, zeraL, zeraR}, 32'h7);
    check("rst_async_pronto", 32'(pronto), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_hold_inicial", 32'(db_estado), 32'h0);
    $display("reset mid-game state=%0h", db_estado);

`ifdef TIMEOUT_EN
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    wait_state(4'h3, 10, "to_enter_wait");
    n = 0;
    while (db_estado === 4'h3 && n < 100) begin
      n++;
      @(negedge clock);
    end
    check("to_cycles_in_wait", 32'(n), 32'(TO));
    check("to_state", 32'(db_estado), 32'hA);
    check("to_flag", 32'(timeout), 32'h1);
    check("to_pronto", 32'(pronto), 32'h1);
    $display("timeout after %0d cycles state=%0h", n, db_estado);

    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    wait_state(4'h3, 10, "to_edge_enter");
    repeat (TO - 1) @(negedge clock);
    play_val = mem[0];
    jogada   = 1'b1;
    @(negedge clock);
    jogada = 1'b0;
    check("to_edge_jogada_wins", 32'(db_estado), 32'h4);
    $display("jogada at last timer cycle state=%0h", db_estado);
    pulse_reset();
`else
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    wait_state(4'h3, 10, "idle_enter");
    stuck = 0;
    repeat (20000) begin
      @(negedge clock);
      if (db_estado !== 4'h3 || timeout !== 1'b0) stuck++;
    end
    check("idle_stays_wait", 32'(stuck), 32'h0);
    check("idle_timeout_low", 32'(timeout), 32'h0);
    play_val = mem[0];
    jogada   = 1'b1;
    @(negedge clock);
    jogada = 1'b0;
    check("idle_then_registra", 32'(db_estado), 32'h4);
    wait_state(4'h7, 10, "idle_then_next_round");
    $display("long idle then play state=%0h", db_estado);
    n = 0;
    check("idle_wait_again", 32'(n), 32'h0);
    wait_state(4'h3, 10, "idle_back_to_wait");
    pulse_reset();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
